// File: rtl/ethernet_tx_axis_scheduler_if.sv
// AXI-Stream bundle between the frame sources, the TX scheduler and the 64-bit MAC.
// Member names keep the scheduler-side direction prefixes so both ends read the same.
interface ethernet_tx_axis_scheduler_if #(
   parameter int N_REQ = 3
);
   logic [N_REQ-1:0]    i_req_axis_tvalid;
   logic [64*N_REQ-1:0] i_req_axis_tdata;
   logic [N_REQ-1:0]    i_req_axis_tlast;
   logic [8*N_REQ-1:0]  i_req_axis_tkeep;
   logic [N_REQ-1:0]    o_req_axis_tready;

   logic                o_tx_axis_tvalid;
   logic [63:0]         o_tx_axis_tdata;
   logic                o_tx_axis_tlast;
   logic [7:0]          o_tx_axis_tkeep;
   logic                i_tx_axis_tready;

   // Sources plus MAC side.
   modport master (
      output i_req_axis_tvalid, i_req_axis_tdata, i_req_axis_tlast, i_req_axis_tkeep,
      input  o_req_axis_tready,
      input  o_tx_axis_tvalid, o_tx_axis_tdata, o_tx_axis_tlast, o_tx_axis_tkeep,
      output i_tx_axis_tready
   );

   // Scheduler side.
   modport slave (
      input  i_req_axis_tvalid, i_req_axis_tdata, i_req_axis_tlast, i_req_axis_tkeep,
      output o_req_axis_tready,
      output o_tx_axis_tvalid, o_tx_axis_tdata, o_tx_axis_tlast, o_tx_axis_tkeep,
      input  i_tx_axis_tready
   );
endinterface

// File: rtl/ethernet_tx_axis_scheduler.sv
// Packet-level round-robin scheduler sharing one 64-bit TX AXI-Stream MAC input between
// N_REQ frame sources; a grant lasts a whole frame and the datapath is a pure mux.
module ethernet_tx_axis_scheduler #(
   parameter int          N_REQ     = 3,
   parameter int unsigned MAX_BEATS = 190
) (
   input  logic                        i_clk,
   input  logic                        i_reset,
   ethernet_tx_axis_scheduler_if.slave bus,
   output logic [N_REQ-1:0]            o_grant,
   output logic                        o_busy,
   output logic [15:0]                 o_frame_count,
   output logic                        o_overrun
);
   localparam int               IDX_W    = $clog2(N_REQ);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_PASS = 1'b1;

   logic [0:0]       state_q, state_d;
   logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
   logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [7:0]       beat_cnt_q, beat_cnt_d;
   logic [15:0]      frame_count_q, frame_count_d;
   logic             overrun_q, overrun_d;

   logic [63:0]      req_data [N_REQ];
   logic [7:0]       req_keep [N_REQ];

   logic             in_pass;
   logic             any_req;
   logic [IDX_W-1:0] pick_idx;
   logic [IDX_W-1:0] cand;
   logic             beat_accept;

   logic             tx_valid;
   logic [63:0]      tx_data;
   logic             tx_last;
   logic [7:0]       tx_keep;
   logic [N_REQ-1:0] req_ready;
   logic [N_REQ-1:0] grant;

   for (genvar k = 0; k < N_REQ; k++) begin : g_unpack
      assign req_data[k] = bus.i_req_axis_tdata[64*k +: 64];
      assign req_keep[k] = bus.i_req_axis_tkeep[8*k +: 8];
   end

   // Search upward from rr_ptr; walking offsets high-to-low lets the nearest request win.
   always_comb begin
      pick_idx = rr_ptr_q;
      any_req  = 1'b0;
      cand     = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (int'(rr_ptr_q) + i >= N_REQ) cand = IDX_W'(int'(rr_ptr_q) + i - N_REQ);
         else                              cand = IDX_W'(int'(rr_ptr_q) + i);
         if (bus.i_req_axis_tvalid[cand]) begin
            pick_idx = cand;
            any_req  = 1'b1;
         end
      end
   end

   always_comb begin
      // NOTE: every signal driven here gets a default first, so no latch can be inferred.
      in_pass   = (state_q == S_PASS);
      tx_valid  = 1'b0;
      tx_data   = '0;
      tx_last   = 1'b0;
      tx_keep   = '0;
      req_ready = '0;
      grant     = '0;
      if (in_pass) begin
         tx_valid             = bus.i_req_axis_tvalid[grant_idx_q];
         tx_data              = req_data[grant_idx_q];
         tx_last              = bus.i_req_axis_tlast[grant_idx_q];
         tx_keep              = req_keep[grant_idx_q];
         req_ready[grant_idx_q] = bus.i_tx_axis_tready;
         grant[grant_idx_q]   = 1'b1;
      end
      beat_accept = in_pass && tx_valid && bus.i_tx_axis_tready;
   end

   always_comb begin
      state_d       = state_q;
      grant_idx_d   = grant_idx_q;
      rr_ptr_d      = rr_ptr_q;
      beat_cnt_d    = beat_cnt_q;
      frame_count_d = frame_count_q;
      overrun_d     = overrun_q;
      case (state_q)
         S_IDLE: begin
            if (any_req) begin
               state_d     = S_PASS;
               grant_idx_d = pick_idx;
               beat_cnt_d  = '0;
            end
         end
         S_PASS: begin
            // Watchdog only flags a runaway frame; the grant is never cut short.
            if (32'(beat_cnt_q) >= MAX_BEATS) overrun_d = 1'b1;
            if (beat_accept) begin
               if (beat_cnt_q != 8'hFF) beat_cnt_d = beat_cnt_q + 8'd1;
               if (tx_last) begin
                  state_d       = S_IDLE;
                  rr_ptr_d      = (grant_idx_q == LAST_IDX) ? '0 : grant_idx_q + IDX_W'(1);
                  frame_count_d = frame_count_q + 16'd1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      // NOTE: sequential state is updated with non-blocking assignments only.
      if (i_reset) begin
         state_q       <= S_IDLE;
         grant_idx_q   <= '0;
         rr_ptr_q      <= '0;
         beat_cnt_q    <= '0;
         frame_count_q <= '0;
         overrun_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         grant_idx_q   <= grant_idx_d;
         rr_ptr_q      <= rr_ptr_d;
         beat_cnt_q    <= beat_cnt_d;
         frame_count_q <= frame_count_d;
         overrun_q     <= overrun_d;
      end
   end

   assign bus.o_tx_axis_tvalid  = tx_valid;
   assign bus.o_tx_axis_tdata   = tx_data;
   assign bus.o_tx_axis_tlast   = tx_last;
   assign bus.o_tx_axis_tkeep   = tx_keep;
   assign bus.o_req_axis_tready = req_ready;
   assign o_grant               = grant;
   assign o_busy                = in_pass;
   assign o_frame_count         = frame_count_q;
   assign o_overrun             = overrun_q;
endmodule

// File: tb/tb_ethernet_tx_axis_scheduler.sv
// Self-checking bench: AXI-Stream source/MAC drivers plus a transaction-level arbiter model
// (owner index, round-robin pointer, frame/overrun tallies) predicting every cycle's outputs.
module tb_ethernet_tx_axis_scheduler;
   localparam int N    = 3;
   localparam int MAXB = 4;

   typedef struct packed {
      logic [63:0] data;
      logic [7:0]  keep;
      logic        last;
   } beat_t;

   logic          clk = 1'b0;
   logic          rst;
   logic [N-1:0]  grant;
   logic          busy;
   logic [15:0]   fcount;
   logic          ovr;

   ethernet_tx_axis_scheduler_if #(.N_REQ(N)) bus ();

   ethernet_tx_axis_scheduler #(.N_REQ(N), .MAX_BEATS(MAXB)) dut (
      .i_clk         (clk),
      .i_reset       (rst),
      .bus           (bus),
      .o_grant       (grant),
      .o_busy        (busy),
      .o_frame_count (fcount),
      .o_overrun     (ovr)
   );

   initial forever #5 clk = ~clk;

   int     n_cmp = 0;
   int     n_bad = 0;
   int     cyc   = 0;

   beat_t  src_q [N][$];
   int     src_hold [N];
   int     src_acc [N];
   bit     gap_rand = 1'b0;
   int     rdy_mode = 0;
   logic   drv_rst  = 1'b1;
   bit     drv_valid [N];
   beat_t  drv_beat [N];
   logic   drv_rdy;

   int     m_owner = -1;
   int     m_rr, m_beats, m_frames;
   bit     m_ovr;
   beat_t  exp_beats[$];
   beat_t  out_beats[$];
   int     exp_order[$];
   int     obs_order[$];
   logic [N-1:0] prev_grant = '0;
   int     pass_cycles;
   logic [97:0] act_vec, exp_vec;

   task automatic add_frame(input int k, input int len, input int tail_bytes);
      beat_t x;
      for (int b = 0; b < len; b++) begin
         x.data = {$urandom, $urandom};
         x.last = (b == len - 1);
         if (!x.last)              x.keep = 8'hFF;
         else if (tail_bytes != 0) x.keep = 8'((1 << tail_bytes) - 1);
         else                      x.keep = 8'((1 << $urandom_range(1, 8)) - 1);
         src_q[k].push_back(x);
      end
   endtask

   // One clock: drive at the falling edge, sample 1 unit before the rising edge.
   task automatic step();
      logic [N-1:0] eg, er;
      beat_t        eb;
      logic         ev;
      bit           found;
      for (int k = 0; k < N; k++) begin
         if (src_hold[k] == 0 && src_q[k].size() != 0) begin
            drv_valid[k] = 1'b1;
            drv_beat[k]  = src_q[k][0];
         end else begin
            drv_valid[k] = 1'b0;
            drv_beat[k]  = beat_t'({$urandom, $urandom, 9'($urandom)});
         end
         if (src_hold[k] != 0) src_hold[k]--;
         bus.i_req_axis_tvalid[k]       = drv_valid[k];
         bus.i_req_axis_tdata[64*k +: 64] = drv_beat[k].data;
         bus.i_req_axis_tkeep[8*k +: 8]   = drv_beat[k].keep;
         bus.i_req_axis_tlast[k]        = drv_beat[k].last;
      end
      case (rdy_mode)
         0:       drv_rdy = 1'b1;
         1:       drv_rdy = (cyc % 2 == 0);
         default: drv_rdy = ($urandom_range(0, 3) != 0);
      endcase
      bus.i_tx_axis_tready = drv_rdy;
      rst = drv_rst;
      #4;
      act_vec = {grant, busy, bus.o_tx_axis_tvalid, bus.o_tx_axis_tlast, bus.o_tx_axis_tkeep,
                 bus.o_tx_axis_tdata, bus.o_req_axis_tready, fcount, ovr};
      eg = '0; er = '0; eb = '0; ev = 1'b0;
      if (m_owner >= 0) begin
         eg[m_owner] = 1'b1;
         er[m_owner] = drv_rdy;
         ev          = drv_valid[m_owner];
         eb          = drv_beat[m_owner];
      end
      exp_vec = {eg, (m_owner >= 0), ev, eb.last, eb.keep, eb.data, er, 16'(m_frames), m_ovr};

      if (bus.o_tx_axis_tvalid === 1'b1) pass_cycles++;
      if (bus.o_tx_axis_tvalid === 1'b1 && drv_rdy)
         out_beats.push_back({bus.o_tx_axis_tdata, bus.o_tx_axis_tkeep, bus.o_tx_axis_tlast});
      if (grant !== '0 && prev_grant === '0) begin
         found = 1'b0;
         for (int k = 0; k < N; k++)
            if (grant[k] === 1'b1 && !found) begin obs_order.push_back(k); found = 1'b1; end
      end
      prev_grant = grant;
      for (int k = 0; k < N; k++) begin
         if (drv_valid[k] && bus.o_req_axis_tready[k] === 1'b1) begin
            void'(src_q[k].pop_front());
            src_acc[k]++;
            if (gap_rand && $urandom_range(0, 3) == 0) src_hold[k] = $urandom_range(1, 3);
         end
      end

      if (drv_rst) begin
         m_owner = -1; m_rr = 0; m_beats = 0; m_frames = 0; m_ovr = 1'b0;
      end else if (m_owner < 0) begin
         found = 1'b0;
         for (int i = 0; i < N; i++) begin
            if (!found && drv_valid[(m_rr + i) % N]) begin
               m_owner = (m_rr + i) % N;
               m_beats = 0;
               exp_order.push_back(m_owner);
               found = 1'b1;
            end
         end
      end else begin
         if (m_beats >= MAXB) m_ovr = 1'b1;
         if (drv_valid[m_owner] && drv_rdy) begin
            exp_beats.push_back(drv_beat[m_owner]);
            if (m_beats < 255) m_beats++;
            if (drv_beat[m_owner].last) begin
               m_frames++;
               m_rr    = (m_owner + 1) % N;
               m_owner = -1;
            end
         end
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   task automatic clear_logs();
      exp_beats.delete(); out_beats.delete();
      exp_order.delete(); obs_order.delete();
      pass_cycles = 0;
      for (int k = 0; k < N; k++) src_acc[k] = 0;
   endtask

   task automatic apply_reset();
      drv_rst = 1'b1;
      for (int k = 0; k < N; k++) begin src_q[k].delete(); src_hold[k] = 0; end
      step();
      step();
      drv_rst = 1'b0;
      rdy_mode = 0;
      gap_rand = 1'b0;
      clear_logs();
   endtask

   function automatic int sb_diffs();
      int d = 0;
      if (out_beats.size() != exp_beats.size()) d++;
      for (int i = 0; i < out_beats.size() && i < exp_beats.size(); i++)
         if (out_beats[i] !== exp_beats[i]) d++;
      return d;
   endfunction

   function automatic int order_diffs(input int a[$], input int b[$]);
      int d = 0;
      if (a.size() != b.size()) d++;
      for (int i = 0; i < a.size() && i < b.size(); i++) if (a[i] != b[i]) d++;
      return d;
   endfunction

   task automatic test_reset();
      apply_reset();
      step();
      n_cmp++;
      if (act_vec !== '0) begin
         n_bad++; $display("FAIL reset_state: got %h want 0", act_vec);
      end
   endtask

   task automatic test_single_arp();
      int want_order[$] = '{0};
      apply_reset();
      add_frame(0, 6, 2);
      repeat (9) begin
         step(); n_cmp++;
         if (act_vec !== exp_vec) begin n_bad++; $display("FAIL arp_cycle %0d: got %h want %h", cyc, act_vec, exp_vec); end
      end
      n_cmp++;
      if (pass_cycles !== 6) begin n_bad++; $display("FAIL arp_valid_cycles: got %0d want 6", pass_cycles); end
      n_cmp++;
      if (out_beats.size() != 6 || out_beats[5].keep !== 8'h03 || out_beats[5].last !== 1'b1) begin
         n_bad++; $display("FAIL arp_tail: got %0d beats want 6 ending keep 03 with tlast", out_beats.size());
      end
      n_cmp++;
      if (order_diffs(obs_order, want_order) != 0) begin n_bad++; $display("FAIL arp_grant: got %p want %p", obs_order, want_order); end
      n_cmp++;
      if (fcount !== 16'd1 || busy !== 1'b0) begin n_bad++; $display("FAIL arp_done: got count %0d busy %b want 1 0", fcount, busy); end
   endtask

   task automatic test_round_robin();
      int want_order[$] = '{0, 1, 2, 0, 1, 2};
      apply_reset();
      for (int k = 0; k < N; k++) begin add_frame(k, 2, 0); add_frame(k, 2, 0); end
      repeat (18) begin
         step(); n_cmp++;
         if (act_vec !== exp_vec) begin n_bad++; $display("FAIL rr_cycle %0d: got %h want %h", cyc, act_vec, exp_vec); end
      end
      n_cmp++;
      if (fcount !== 16'd6) begin n_bad++; $display("FAIL rr_count: got %0d want 6", fcount); end
      n_cmp++;
      if (order_diffs(obs_order, want_order) != 0) begin n_bad++; $display("FAIL rr_order: got %p want %p", obs_order, want_order); end
      n_cmp++;
      if (sb_diffs() != 0) begin n_bad++; $display("FAIL rr_data: got %0d bad beats want 0", sb_diffs()); end
   endtask

   task automatic test_backpressure();
      apply_reset();
      rdy_mode = 1;
      add_frame(2, 10, 0);
      for (int g = 0; g < 40 && fcount !== 16'd1; g++) begin
         step(); n_cmp++;
         if (act_vec !== exp_vec) begin n_bad++; $display("FAIL bp_cycle %0d: got %h want %h", cyc, act_vec, exp_vec); end
      end
      n_cmp++;
      if (fcount !== 16'd1) begin n_bad++; $display("FAIL bp_count: got %0d want 1", fcount); end
      n_cmp++;
      if (out_beats.size() != 10 || sb_diffs() != 0) begin
         n_bad++; $display("FAIL bp_data: got %0d beats, %0d bad, want 10 and 0", out_beats.size(), sb_diffs());
      end
   endtask

   task automatic test_valid_gap();
      int  want_order[$] = '{1, 0};
      bit  gap_done = 1'b0;
      apply_reset();
      add_frame(1, 8, 0);
      step();
      add_frame(0, 2, 0);
      for (int g = 0; g < 40 && fcount !== 16'd2; g++) begin
         if (src_acc[1] == 4 && !gap_done) begin src_hold[1] = 3; gap_done = 1'b1; end
         step(); n_cmp++;
         if (act_vec !== exp_vec) begin n_bad++; $display("FAIL gap_cycle %0d: got %h want %h", cyc, act_vec, exp_vec); end
      end
      n_cmp++;
      if (order_diffs(obs_order, want_order) != 0 || fcount !== 16'd2) begin
         n_bad++; $display("FAIL gap_order: got %p count %0d want %p count 2", obs_order, fcount, want_order);
      end
      n_cmp++;
      if (sb_diffs() != 0) begin n_bad++; $display("FAIL gap_data: got %0d bad beats want 0", sb_diffs()); end
   endtask

   task automatic test_watchdog();
      apply_reset();
      add_frame(2, MAXB, 0);
      for (int g = 0; g < 20 && fcount !== 16'd1; g++) begin
         step(); n_cmp++;
         if (act_vec !== exp_vec) begin n_bad++; $display("FAIL wd_edge_cycle %0d: got %h want %h", cyc, act_vec, exp_vec); end
      end
      step();
      n_cmp++;
      if (fcount !== 16'd1 || ovr !== 1'b0) begin n_bad++; $display("FAIL wd_exact_len: got count %0d ovr %b want 1 0", fcount, ovr); end
      add_frame(0, 7, 0);
      for (int g = 0; g < 20 && fcount !== 16'd2; g++) begin
         step(); n_cmp++;
         if (act_vec !== exp_vec) begin n_bad++; $display("FAIL wd_cycle %0d: got %h want %h", cyc, act_vec, exp_vec); end
      end
      repeat (3) step();
      n_cmp++;
      if (ovr !== 1'b1 || fcount !== 16'd2) begin n_bad++; $display("FAIL wd_sticky: got ovr %b count %0d want 1 2", ovr, fcount); end
      n_cmp++;
      if (out_beats.size() != MAXB + 7 || sb_diffs() != 0) begin
         n_bad++; $display("FAIL wd_data: got %0d beats, %0d bad, want %0d and 0", out_beats.size(), sb_diffs(), MAXB + 7);
      end
   endtask

   task automatic test_reset_mid_frame();
      int want_order[$] = '{0, 1};
      apply_reset();
      add_frame(0, 1, 0);
      for (int g = 0; g < 10 && fcount !== 16'd1; g++) step();
      add_frame(1, 6, 0);
      for (int g = 0; g < 20 && src_acc[1] < 2; g++) begin
         step(); n_cmp++;
         if (act_vec !== exp_vec) begin n_bad++; $display("FAIL rst_pre_cycle %0d: got %h want %h", cyc, act_vec, exp_vec); end
      end
      n_cmp++;
      if (fcount !== 16'd1 || busy !== 1'b1) begin n_bad++; $display("FAIL rst_pre_state: got count %0d busy %b want 1 1", fcount, busy); end
      drv_rst = 1'b1;
      step();
      drv_rst = 1'b0;
      n_cmp++;
      if (bus.o_tx_axis_tvalid !== 1'b0 || grant !== '0 || fcount !== 16'd0 || ovr !== 1'b0) begin
         n_bad++; $display("FAIL rst_mid: got tvalid %b grant %b count %0d ovr %b want 0 0 0 0",
                           bus.o_tx_axis_tvalid, grant, fcount, ovr);
      end
      for (int k = 0; k < N; k++) src_q[k].delete();
      clear_logs();
      add_frame(0, 3, 0);
      add_frame(1, 2, 0);
      for (int g = 0; g < 20 && fcount !== 16'd2; g++) begin
         step(); n_cmp++;
         if (act_vec !== exp_vec) begin n_bad++; $display("FAIL rst_post_cycle %0d: got %h want %h", cyc, act_vec, exp_vec); end
      end
      n_cmp++;
      if (order_diffs(obs_order, want_order) != 0 || fcount !== 16'd2) begin
         n_bad++; $display("FAIL rst_post_order: got %p count %0d want %p count 2", obs_order, fcount, want_order);
      end
   endtask

   task automatic test_random();
      int frames = 0;
      int k;
      int guard = 0;
      apply_reset();
      rdy_mode = 2;
      gap_rand = 1'b1;
      repeat (400) begin
         if ($urandom_range(0, 9) == 0) begin
            k = $urandom_range(0, N - 1);
            if (src_q[k].size() < 20) begin add_frame(k, $urandom_range(1, 6), 0); frames++; end
         end
         step(); n_cmp++;
         if (act_vec !== exp_vec) begin n_bad++; $display("FAIL rand_cycle %0d: got %h want %h", cyc, act_vec, exp_vec); end
      end
      while ((src_q[0].size() + src_q[1].size() + src_q[2].size() != 0 || m_owner >= 0) && guard < 2000) begin
         step(); n_cmp++;
         if (act_vec !== exp_vec) begin n_bad++; $display("FAIL rand_drain_cycle %0d: got %h want %h", cyc, act_vec, exp_vec); end
         guard++;
      end
      n_cmp++;
      if (guard >= 2000) begin n_bad++; $display("FAIL rand_drain_timeout: got %0d cycles want < 2000", guard); end
      n_cmp++;
      if (fcount !== 16'(frames)) begin n_bad++; $display("FAIL rand_count: got %0d want %0d", fcount, frames); end
      n_cmp++;
      if (sb_diffs() != 0) begin n_bad++; $display("FAIL rand_data: got %0d bad beats want 0", sb_diffs()); end
      n_cmp++;
      if (order_diffs(obs_order, exp_order) != 0) begin
         n_bad++; $display("FAIL rand_order: got %0d grants want %0d", obs_order.size(), exp_order.size());
      end
      gap_rand = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single_arp();
      test_round_robin();
      test_backpressure();
      test_valid_gap();
      test_watchdog();
      test_reset_mid_frame();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL global_timeout: simulation did not finish within time limit");
      $fatal(1, "timeout");
   end
endmodule
